// File: rtl/saadi_pkg.sv
// Shared constants and arithmetic helpers for the SAADI-EC result capture block.
// Helpers work on a 32-bit result / 64-bit quotient container, and callers slice to n.
package saadi_pkg;

  localparam int N_DEF        = 8;
  localparam int FRAC_OUT_DEF = 4;
  localparam int DEPTH_DEF    = 4;

  localparam int MAXW = 32;
  localparam int SW   = 2 * MAXW + 1;

  typedef struct packed {
    logic            sat;
    logic [MAXW-1:0] res;
  } rs_t;

  // Target one-hot count for iteration count t; zero when t is outside the n-bit counter.
  function automatic logic [MAXW-1:0] onehot_target(input int t, input int n);
    logic [MAXW-1:0] one;
    one = MAXW'(1);
    if (t >= 0 && t < n) return one << t;
    return '0;
  endfunction

  // Round half-up to frac fraction bits, then clamp to n unsigned bits.
  function automatic rs_t round_sat(input logic [2*MAXW-1:0] qc, input int n, input int frac);
    int            s;
    logic [SW-1:0] sum;
    logic [SW-1:0] r;
    logic [SW-1:0] lim;
    rs_t           o;
    s   = n - 1 - frac;
    sum = {1'b0, qc};
    if (s > 0) sum = sum + (SW'(1) << (s - 1));
    r   = sum >> s;
    lim = SW'(1) << n;
    if (r >= lim) begin
      o.sat = 1'b1;
      o.res = MAXW'(lim - SW'(1));
    end else begin
      o.sat = 1'b0;
      o.res = r[MAXW-1:0];
    end
    return o;
  endfunction

endpackage

// File: rtl/saadi_sync_fifo.sv
// Synchronous FIFO with occupancy count; a push into a full FIFO only lands if a pop
// happens in the same cycle, and an empty FIFO never forwards din straight to dout.
module saadi_sync_fifo #(
  parameter int WIDTH = 9,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = empty ? '0 : mem[rd_ptr];
  assign level   = count;

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // Pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/saadi_result_capture.sv
// Follows the core's one-hot iteration counter, captures the rounded/saturated quotient
// at the end of each window, and queues results toward the sink.
module saadi_result_capture
  import saadi_pkg::*;
#(
  parameter int n        = N_DEF,
  parameter int FRAC_OUT = FRAC_OUT_DEF,
  parameter int DEPTH    = DEPTH_DEF
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [n-1:0]           t,
  input  logic [2*n-1:0]         Qc,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [n-1:0]           out_res,
  output logic                   out_sat,
  output logic                   ovf,
  output logic [$clog2(DEPTH):0] level
);

  logic [n-1:0]    cnt;
  logic [MAXW-1:0] target_w;
  logic [n-1:0]    target;
  logic            sample;
  rs_t             rs;
  logic [n:0]      stage;
  logic            stage_v;
  logic [n:0]      head;
  logic            full;
  logic            empty;
  logic            pop;

  assign target_w = onehot_target(int'(32'(t)), n);
  assign target   = target_w[n-1:0];
  assign sample   = (cnt == target);
  assign rs       = round_sat(64'(Qc), n, FRAC_OUT);

  assign pop       = out_ready && !empty;
  assign out_valid = !empty;
  assign out_sat   = head[n];
  assign out_res   = head[n-1:0];

  // A window ends on the compare hit; the counter then restarts at bit1, mirroring the core.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt     <= n'(1);
      stage   <= '0;
      stage_v <= 1'b0;
      ovf     <= 1'b0;
    end else begin
      cnt     <= sample ? n'(2) : {cnt[n-2:0], cnt[n-1]};
      stage_v <= sample;
      if (sample) stage <= {rs.sat, rs.res[n-1:0]};
      if (stage_v && full && !pop) ovf <= 1'b1;
    end
  end

  saadi_sync_fifo #(
    .WIDTH(n + 1),
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk  (clk),
    .reset(reset),
    .push (stage_v),
    .din  (stage),
    .pop  (pop),
    .dout (head),
    .full (full),
    .empty(empty),
    .level(level)
  );

endmodule

// File: tb/tb_saadi_result_capture.sv
// Directed bench for saadi_result_capture (n=8, FRAC_OUT=4, DEPTH=4).
module tb_saadi_result_capture;

  logic        clk;
  logic        reset;
  logic [7:0]  t;
  logic [15:0] Qc;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_res;
  logic        out_sat;
  logic        ovf;
  logic [2:0]  level;

  int assertCount = 0;
  int failCount   = 0;
  int edgeNo      = 0;
  logic seen;

  saadi_result_capture #(.n(8), .FRAC_OUT(4), .DEPTH(4)) dut (
    .clk      (clk),
    .reset    (reset),
    .t        (t),
    .Qc       (Qc),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_res  (out_res),
    .out_sat  (out_sat),
    .ovf      (ovf),
    .level    (level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic applyStimulus(input int edges);
    repeat (edges) begin
      @(posedge clk);
      #1;
      edgeNo++;
    end
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    assertCount++;
    assert (observed === expected)
    else begin
      failCount++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  initial begin
    // Reset state
    reset = 1'b1; t = 8'd7; Qc = 16'h0180; out_ready = 1'b1;
    applyStimulus(2);
    checkOutput("rst_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_level", 32'(level), 32'd0);
    checkOutput("rst_ovf", 32'(ovf), 32'd0);
    checkOutput("rst_res", 32'(out_res), 32'd0);
    checkOutput("rst_sat", 32'(out_sat), 32'd0);
    checkOutput("rst_cnt", 32'(dut.cnt), 32'd1);

    // t=7: sample at edge 8, result visible after edge 9, then every 7 edges
    reset = 1'b0; edgeNo = 0;
    applyStimulus(8);
    checkOutput("t7_e8_valid", 32'(out_valid), 32'd0);
    checkOutput("t7_e8_stage_v", 32'(dut.stage_v), 32'd1);
    Qc = 16'h0184;
    applyStimulus(1);
    checkOutput("t7_e9_valid", 32'(out_valid), 32'd1);
    checkOutput("q0180_res", 32'(out_res), 32'h30);
    checkOutput("q0180_sat", 32'(out_sat), 32'd0);
    applyStimulus(1);
    checkOutput("t7_e10_popped", 32'(out_valid), 32'd0);
    applyStimulus(5);
    checkOutput("t7_e15_valid", 32'(out_valid), 32'd0);
    applyStimulus(1);
    checkOutput("t7_e16_valid", 32'(out_valid), 32'd1);
    checkOutput("q0184_res", 32'(out_res), 32'h31);
    Qc = 16'h0183;
    applyStimulus(7);
    checkOutput("q0183_valid", 32'(out_valid), 32'd1);
    checkOutput("q0183_res", 32'(out_res), 32'h30);
    Qc = 16'd2043;
    applyStimulus(7);
    checkOutput("q2043_res", 32'(out_res), 32'hFF);
    checkOutput("q2043_sat", 32'(out_sat), 32'd0);
    Qc = 16'd2044;
    applyStimulus(7);
    checkOutput("q2044_res", 32'(out_res), 32'hFF);
    checkOutput("q2044_sat", 32'(out_sat), 32'd1);
    Qc = 16'hFFFF;
    applyStimulus(7);
    checkOutput("qFFFF_res", 32'(out_res), 32'hFF);
    checkOutput("qFFFF_sat", 32'(out_sat), 32'd1);

    // t=1 with sink stalled: six samples, last two dropped
    reset = 1'b1; t = 8'd1; out_ready = 1'b0;
    applyStimulus(1);
    reset = 1'b0; Qc = 16'd8;
    applyStimulus(1);
    for (int k = 1; k <= 6; k++) begin
      Qc = 16'(k * 8);
      applyStimulus(1);
    end
    t = 8'd8;
    applyStimulus(1);
    checkOutput("ovf_level", 32'(level), 32'd4);
    checkOutput("ovf_flag", 32'(ovf), 32'd1);
    checkOutput("ovf_valid", 32'(out_valid), 32'd1);
    checkOutput("ovf_head1", 32'(out_res), 32'd1);
    applyStimulus(1);
    checkOutput("ovf_hold_res", 32'(out_res), 32'd1);
    checkOutput("ovf_hold_level", 32'(level), 32'd4);
    out_ready = 1'b1;
    for (int k = 2; k <= 4; k++) begin
      applyStimulus(1);
      checkOutput($sformatf("drain_head%0d", k), 32'(out_res), 32'(k));
    end
    applyStimulus(1);
    checkOutput("drain_empty", 32'(out_valid), 32'd0);
    checkOutput("drain_level", 32'(level), 32'd0);
    checkOutput("drain_ovf_sticky", 32'(ovf), 32'd1);

    // Full FIFO with simultaneous push and pop
    reset = 1'b1; t = 8'd1; out_ready = 1'b0;
    applyStimulus(1);
    reset = 1'b0; Qc = 16'd8;
    applyStimulus(1);
    for (int k = 1; k <= 5; k++) begin
      Qc = 16'(k * 8);
      applyStimulus(1);
    end
    checkOutput("sim_full_level", 32'(level), 32'd4);
    checkOutput("sim_full_ovf", 32'(ovf), 32'd0);
    out_ready = 1'b1; t = 8'd8;
    applyStimulus(1);
    checkOutput("sim_level", 32'(level), 32'd4);
    checkOutput("sim_ovf", 32'(ovf), 32'd0);
    checkOutput("sim_head2", 32'(out_res), 32'd2);
    out_ready = 1'b0;
    applyStimulus(1);
    checkOutput("sim_hold", 32'(out_res), 32'd2);
    out_ready = 1'b1;
    for (int k = 3; k <= 5; k++) begin
      applyStimulus(1);
      checkOutput($sformatf("sim_head%0d", k), 32'(out_res), 32'(k));
    end
    applyStimulus(1);
    checkOutput("sim_empty", 32'(out_valid), 32'd0);

    // Reset mid-queue with a result still in the stage register
    reset = 1'b1; t = 8'd1; out_ready = 1'b0;
    applyStimulus(1);
    reset = 1'b0; Qc = 16'd8;
    applyStimulus(1);
    for (int k = 1; k <= 4; k++) begin
      Qc = 16'(k * 8);
      applyStimulus(1);
    end
    checkOutput("mid_level3", 32'(level), 32'd3);
    checkOutput("mid_stage_v", 32'(dut.stage_v), 32'd1);
    reset = 1'b1;
    applyStimulus(1);
    checkOutput("mid_rst_valid", 32'(out_valid), 32'd0);
    checkOutput("mid_rst_level", 32'(level), 32'd0);
    checkOutput("mid_rst_ovf", 32'(ovf), 32'd0);
    checkOutput("mid_rst_cnt", 32'(dut.cnt), 32'd1);
    checkOutput("mid_rst_stage_v", 32'(dut.stage_v), 32'd0);

    // t >= n: no sample ever fires
    t = 8'd8; out_ready = 1'b1; reset = 1'b0; seen = 1'b0;
    for (int k = 0; k < 40; k++) begin
      Qc = 16'(k * 37);
      applyStimulus(1);
      if (out_valid || dut.stage_v) seen = 1'b1;
    end
    checkOutput("t8_no_samples", 32'(seen), 32'd0);
    checkOutput("t8_level", 32'(level), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
